// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core's instruction fetch buffer.
package idli_pkg;

    typedef logic [15:0] instr_t;

    localparam int IBUF_DEPTH   = 2;
    localparam int NIB_PER_WORD = 4;

    typedef logic [$clog2(IBUF_DEPTH+1)-1:0] ibuf_cnt_t;

    // Position of the next nibble within the word being assembled.
    typedef enum logic [1:0] {
        NIB_EMPTY = 2'd0,
        NIB_N1    = 2'd1,
        NIB_N2    = 2'd2,
        NIB_N3    = 2'd3
    } nib_state_t;

endpackage

// File: rtl/idli_ibuf_if.sv
// Fetch/decode side bundle of the instruction buffer: nibble stream in, instruction words out.
interface idli_ibuf_if #(
    parameter int DEPTH = idli_pkg::IBUF_DEPTH
);
    import idli_pkg::*;

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [3:0]       i_ibuf_nib;
    logic             i_ibuf_nib_vld;
    logic             o_ibuf_rdy;
    logic             i_ibuf_flush;
    instr_t           o_ibuf_instr;
    logic             o_ibuf_instr_vld;
    logic             i_ibuf_instr_acp;
    logic [CNT_W-1:0] o_ibuf_cnt;

    // master: fetch + decode driving the buffer; slave: the buffer itself.
    modport master (
        output i_ibuf_nib, i_ibuf_nib_vld, i_ibuf_flush, i_ibuf_instr_acp,
        input  o_ibuf_rdy, o_ibuf_instr, o_ibuf_instr_vld, o_ibuf_cnt
    );

    modport slave (
        input  i_ibuf_nib, i_ibuf_nib_vld, i_ibuf_flush, i_ibuf_instr_acp,
        output o_ibuf_rdy, o_ibuf_instr, o_ibuf_instr_vld, o_ibuf_cnt
    );

endinterface

// File: rtl/idli_ibuf_fifo_m.sv
// Synchronous FIFO of instruction words with flush, occupancy count and a registered head.
module idli_ibuf_fifo_m
    import idli_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  instr_t           push_data,
    input  logic             pop,
    output instr_t           head,
    output logic             head_vld,
    output logic [CNT_W-1:0] cnt
);

    instr_t           mem_q [DEPTH];
    instr_t           head_q;
    instr_t           head_nxt;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

    // NOTE: every output of this block is assigned before any branch, so no latch can be inferred.
    always_comb begin
        rd_ptr_nxt = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_nxt    = cnt_q;
        head_nxt   = head_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_nxt = cnt_q + 1'b1;
            2'b01:   cnt_nxt = cnt_q - 1'b1;
            default: cnt_nxt = cnt_q;
        endcase
        // Head only moves while a word will be present; otherwise it keeps its last value.
        if (cnt_nxt != '0) begin
            head_nxt = (do_push && (wr_ptr_q == rd_ptr_nxt)) ? push_data : mem_q[rd_ptr_nxt];
        end
    end

    // NOTE: the storage array is deliberately not reset; only the head register is cleared.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            rd_ptr_q <= rd_ptr_nxt;
            cnt_q    <= cnt_nxt;
            head_q   <= head_nxt;
        end
    end

    assign head     = head_q;
    assign head_vld = (cnt_q != '0);
    assign cnt      = cnt_q;

endmodule

// File: rtl/idli_ibuf_m.sv
// Instruction fetch buffer: packs SQI nibbles (MSB first) into 16-bit words for decode.
// Define IDLI_IBUF_BYPASS_EN to forward a completing word straight to decode when the FIFO is empty.
module idli_ibuf_m
    import idli_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH,
    localparam int CNT_W = $clog2(DEPTH+1)
) (
    input  logic       i_ibuf_gck,
    input  logic       i_ibuf_rst,
    idli_ibuf_if.slave ibuf
);

    nib_state_t       nib_state;
    logic [11:0]      asm_q;
    logic             rdy;
    logic             nib_acc;
    logic             word_done;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_vld;
    instr_t           fifo_head;
    instr_t           word;
    logic [CNT_W-1:0] fifo_cnt;

    // A word is only started with a free slot; once started it is always allowed to finish.
    assign rdy       = (nib_state != NIB_EMPTY) || (fifo_cnt < CNT_W'(DEPTH));
    assign nib_acc   = ibuf.i_ibuf_nib_vld && rdy && !ibuf.i_ibuf_flush;
    assign word_done = nib_acc && (nib_state == nib_state_t'(NIB_PER_WORD-1));
    assign word      = {asm_q, ibuf.i_ibuf_nib};

    // NOTE: sequential state uses <= so every register samples pre-edge values of its peers.
    always_ff @(posedge i_ibuf_gck) begin
        if (i_ibuf_rst || ibuf.i_ibuf_flush) begin
            nib_state <= NIB_EMPTY;
            asm_q     <= '0;
        end else if (nib_acc) begin
            asm_q <= {asm_q[7:0], ibuf.i_ibuf_nib};
            unique case (nib_state)
                NIB_EMPTY: nib_state <= NIB_N1;
                NIB_N1:    nib_state <= NIB_N2;
                NIB_N2:    nib_state <= NIB_N3;
                NIB_N3:    nib_state <= NIB_EMPTY;
                default:   nib_state <= NIB_EMPTY;
            endcase
        end
    end

`ifdef IDLI_IBUF_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit            = word_done && (fifo_cnt == '0);
    assign fifo_push             = word_done && !(bypass_hit && ibuf.i_ibuf_instr_acp);
    assign ibuf.o_ibuf_instr     = bypass_hit ? word : fifo_head;
    assign ibuf.o_ibuf_instr_vld = fifo_vld || bypass_hit;
`else
    assign fifo_push             = word_done;
    assign ibuf.o_ibuf_instr     = fifo_head;
    assign ibuf.o_ibuf_instr_vld = fifo_vld;
`endif

    assign fifo_pop = fifo_vld && ibuf.i_ibuf_instr_acp;

    idli_ibuf_fifo_m #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_ibuf_gck),
        .rst       (i_ibuf_rst),
        .flush     (ibuf.i_ibuf_flush),
        .push      (fifo_push),
        .push_data (word),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .head_vld  (fifo_vld),
        .cnt       (fifo_cnt)
    );

    assign ibuf.o_ibuf_rdy = rdy;
    assign ibuf.o_ibuf_cnt = fifo_cnt;

    // A nibble offered while not ready is silently dropped by the buffer; flag it to the fetch owner.
    a_nib_when_busy: assert property (
        @(posedge i_ibuf_gck) disable iff (i_ibuf_rst)
        !(ibuf.i_ibuf_nib_vld && !rdy && !ibuf.i_ibuf_flush)
    ) else $warning("idli_ibuf: nibble presented while buffer not ready, ignored");

endmodule

// File: tb/tb_idli_ibuf_m.sv
// Scoreboard bench for idli_ibuf_m: directed nibble streams, monitor checks every consumed word.
module tb_idli_ibuf_m;
    import idli_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    int     checks = 0;
    int     errors = 0;
    int     max_cnt = 0;
    instr_t exp_q[$];

    idli_ibuf_if #(.DEPTH(IBUF_DEPTH)) bus ();

    idli_ibuf_m #(.DEPTH(IBUF_DEPTH)) dut (
        .i_ibuf_gck (clk),
        .i_ibuf_rst (rst),
        .ibuf       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (int'(bus.o_ibuf_cnt) > max_cnt) max_cnt = int'(bus.o_ibuf_cnt);
    endtask

    task automatic send_nib(input logic [3:0] n);
        bus.i_ibuf_nib     = n;
        bus.i_ibuf_nib_vld = 1'b1;
        step();
        bus.i_ibuf_nib_vld = 1'b0;
    endtask

    task automatic send_word(input instr_t w);
        exp_q.push_back(w);
        send_nib(w[15:12]);
        send_nib(w[11:8]);
        send_nib(w[7:4]);
        send_nib(w[3:0]);
    endtask

    task automatic drain(input string name);
        bus.i_ibuf_instr_acp = 1'b1;
        for (int i = 0; i < 8 && bus.o_ibuf_instr_vld; i++) step();
        bus.i_ibuf_instr_acp = 1'b0;
        check({name, "_drained_vld"}, bus.o_ibuf_instr_vld, 0);
        check({name, "_drained_cnt"}, bus.o_ibuf_cnt, 0);
    endtask

    // Monitor: any word decode consumes must be the next expected one.
    always @(negedge clk) begin
        if (!rst && bus.o_ibuf_instr_vld && bus.i_ibuf_instr_acp && !bus.i_ibuf_flush) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", bus.o_ibuf_instr, 16'hxxxx);
            end else begin
                check("word_order", bus.o_ibuf_instr, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                  = 1'b1;
        bus.i_ibuf_nib       = 4'h0;
        bus.i_ibuf_nib_vld   = 1'b0;
        bus.i_ibuf_flush     = 1'b0;
        bus.i_ibuf_instr_acp = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_cnt", bus.o_ibuf_cnt, 0);
        check("reset_vld", bus.o_ibuf_instr_vld, 0);
        check("reset_rdy", bus.o_ibuf_rdy, 1);
        check("reset_instr", bus.o_ibuf_instr, 16'h0000);

        // Single word, no accept: visible one cycle after the last nibble.
        exp_q.push_back(16'hABCD);
        send_nib(4'hA);
        send_nib(4'hB);
        send_nib(4'hC);
        bus.i_ibuf_nib     = 4'hD;
        bus.i_ibuf_nib_vld = 1'b1;
        #1;
`ifdef IDLI_IBUF_BYPASS_EN
        check("abcd_bypass_vld", bus.o_ibuf_instr_vld, 1);
`else
        check("abcd_early_vld", bus.o_ibuf_instr_vld, 0);
`endif
        step();
        bus.i_ibuf_nib_vld = 1'b0;
        check("abcd_vld", bus.o_ibuf_instr_vld, 1);
        check("abcd_instr", bus.o_ibuf_instr, 16'hABCD);
        check("abcd_cnt", bus.o_ibuf_cnt, 1);
        drain("abcd");

        // Fill to DEPTH, offer a nibble while not ready, then free one slot.
        send_word(16'h1234);
        send_word(16'h5678);
        check("full_rdy", bus.o_ibuf_rdy, 0);
        check("full_cnt", bus.o_ibuf_cnt, 2);
        send_nib(4'h9);
        check("ignored_cnt", bus.o_ibuf_cnt, 2);
        check("ignored_head", bus.o_ibuf_instr, 16'h1234);
        check("ignored_rdy", bus.o_ibuf_rdy, 0);
        bus.i_ibuf_instr_acp = 1'b1;
        step();
        bus.i_ibuf_instr_acp = 1'b0;
        check("after_pop_rdy", bus.o_ibuf_rdy, 1);
        check("after_pop_cnt", bus.o_ibuf_cnt, 1);
        check("after_pop_head", bus.o_ibuf_instr, 16'h5678);
        send_word(16'h9ABC);
        check("refill_cnt", bus.o_ibuf_cnt, 2);
        drain("fill");

        // Continuous stream with decode always accepting.
        max_cnt = 0;
        bus.i_ibuf_instr_acp = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_word(instr_t'(16'h0F0F + i * 16'h1357));
        end
        drain("stream");
`ifdef IDLI_IBUF_BYPASS_EN
        check("stream_max_cnt", max_cnt, 0);
`else
        check("stream_max_cnt", max_cnt, 1);
`endif

        // Flush mid-word drops the partial word.
        send_nib(4'hE);
        send_nib(4'hF);
        exp_q.delete();
        bus.i_ibuf_nib       = 4'h0;
        bus.i_ibuf_nib_vld   = 1'b1;
        bus.i_ibuf_flush     = 1'b1;
        step();
        bus.i_ibuf_nib_vld   = 1'b0;
        bus.i_ibuf_flush     = 1'b0;
        check("midflush_cnt", bus.o_ibuf_cnt, 0);
        check("midflush_rdy", bus.o_ibuf_rdy, 1);
        send_word(16'h1234);
        check("midflush_next_head", bus.o_ibuf_instr, 16'h1234);
        drain("midflush");

        // Flush with a full FIFO and a simultaneous accept.
        send_word(16'h1111);
        send_word(16'h2222);
        check("preflush_cnt", bus.o_ibuf_cnt, 2);
        exp_q.delete();
        bus.i_ibuf_flush     = 1'b1;
        bus.i_ibuf_instr_acp = 1'b1;
        step();
        bus.i_ibuf_flush     = 1'b0;
        bus.i_ibuf_instr_acp = 1'b0;
        check("flush_cnt", bus.o_ibuf_cnt, 0);
        check("flush_vld", bus.o_ibuf_instr_vld, 0);
        check("flush_rdy", bus.o_ibuf_rdy, 1);
        send_word(16'h3333);
        check("postflush_cnt", bus.o_ibuf_cnt, 1);
        check("postflush_head", bus.o_ibuf_instr, 16'h3333);
        drain("postflush");

        // Empty FIFO, decode accepting, word 0xCAFE.
        bus.i_ibuf_instr_acp = 1'b1;
        exp_q.push_back(16'hCAFE);
        send_nib(4'hC);
        send_nib(4'hA);
        send_nib(4'hF);
        bus.i_ibuf_nib     = 4'hE;
        bus.i_ibuf_nib_vld = 1'b1;
        #1;
`ifdef IDLI_IBUF_BYPASS_EN
        check("cafe_same_cycle_vld", bus.o_ibuf_instr_vld, 1);
        check("cafe_same_cycle_instr", bus.o_ibuf_instr, 16'hCAFE);
        step();
        bus.i_ibuf_nib_vld = 1'b0;
        check("cafe_cnt", bus.o_ibuf_cnt, 0);
        check("cafe_after_vld", bus.o_ibuf_instr_vld, 0);
`else
        check("cafe_same_cycle_vld", bus.o_ibuf_instr_vld, 0);
        step();
        bus.i_ibuf_nib_vld = 1'b0;
        check("cafe_vld", bus.o_ibuf_instr_vld, 1);
        check("cafe_instr", bus.o_ibuf_instr, 16'hCAFE);
        check("cafe_cnt", bus.o_ibuf_cnt, 1);
`endif
        drain("cafe");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idli_ibuf_m.md
Name: idli_ibuf_m

Overview:
Instruction fetch buffer between the SQI read-data flop and the instruction decoder. Assembles the 4-bit nibble stream returned by the SQI memory into 16-bit instruction words and queues them in a small FIFO. Presents the words to decode over a valid/accept handshake. Back-pressures fetch at word boundaries and is flushed on PC redirect.

Parameters:
DEPTH, 2, number of 16-bit instruction words held in the FIFO (power of two, >= 2)
NIB_PER_WORD, 4, nibbles per instruction word; fixed by the ISA and not to be overridden

Ports:
i_ibuf_gck  input  1  core clock; all state updates on the rising edge
i_ibuf_rst  input  1  synchronous, active-high reset
i_ibuf_nib  input  4  SQI read nibble (registered upstream)
i_ibuf_nib_vld  input  1  i_ibuf_nib valid this cycle
o_ibuf_rdy  output  1  buffer can take i_ibuf_nib this cycle
i_ibuf_flush  input  1  discard all buffered and partial state (PC redirect)
o_ibuf_instr  output  16  head instruction word
o_ibuf_instr_vld  output  1  o_ibuf_instr valid
i_ibuf_instr_acp  input  1  decode consumes the head word this cycle
o_ibuf_cnt  output  $clog2(DEPTH+1)  number of complete words in the FIFO

Behaviour:
- Reset is synchronous and active-high. While i_ibuf_rst is high at a rising edge: FIFO count=0, read/write pointers=0, nibble counter=0, assembly register=0. After reset: o_ibuf_instr_vld=0, o_ibuf_cnt=0, o_ibuf_rdy=1, o_ibuf_instr=0 (head storage is also cleared).
- Nibble order is most-significant first: nibble 0 -> [15:12], nibble 1 -> [11:8], nibble 2 -> [7:4], nibble 3 -> [3:0].
- Nibble accept = i_ibuf_nib_vld & o_ibuf_rdy & !i_ibuf_flush.
  - Nibbles 0-2 shift into the assembly register and increment the nibble counter.
  - Nibble 3 pushes {asm[11:0], nib} into the FIFO and returns the counter to 0.
- o_ibuf_rdy = (nib_cnt != 0) | (fifo_cnt < DEPTH). A word is only started if a slot is free, and a started word always completes, so a push never overflows.
- A nibble presented while o_ibuf_rdy=0 is ignored; the state is unchanged. This is a protocol error and simulation flags it.
- Latency: nibble 3 accepted in cycle N -> o_ibuf_instr_vld=1 in cycle N+1 (head is registered).
- Pop occurs when o_ibuf_instr_vld & i_ibuf_instr_acp. An accept while vld=0 is ignored.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at any count including DEPTH-1.
- Pointers wrap modulo DEPTH. Count saturates only by construction; it never exceeds DEPTH and never underflows.
- Flush takes priority over push and pop in the same cycle. Next cycle: count=0, pointers=0, nibble counter=0, vld=0, rdy=1. A nibble presented with flush is discarded. A flush arriving mid-word (nib_cnt 1-3) drops the partial word.
- Reset has priority over flush and mid-operation activity. Partial words are lost.
- o_ibuf_instr holds its last value when vld=0; consumers must not sample it.
- Nibble counter state machine: EMPTY(0) -> N1 -> N2 -> N3 -> EMPTY on each accepted nibble. Flush or reset returns it to EMPTY.

Optional Feature:
IDLI_IBUF_BYPASS_EN
- Defined: when the FIFO is empty and nibble 3 is accepted, o_ibuf_instr={asm[11:0], nib} and o_ibuf_instr_vld=1 in that same cycle (combinational path). If i_ibuf_instr_acp is also high, the word is consumed and not written; otherwise it is written normally. Flush in the same cycle forces vld=0.
- Undefined: no combinational path from i_ibuf_nib to o_ibuf_instr; latency is N+1 as above.

Decomposition:
- idli_pkg gains:
  - typedef instr_t (logic [15:0])
  - localparam IBUF_DEPTH=2
  - localparam NIB_PER_WORD=4
  - typedef ibuf_cnt_t sized for 0..IBUF_DEPTH
- One sub-module, idli_ibuf_fifo_m: a generic synchronous FIFO of instr_t with push/pop/flush, count, and registered head.
- The nibble assembler stays in idli_ibuf_m.

Test Plan:
- Reset then feed nibbles 0xA,0xB,0xC,0xD on consecutive cycles with acp=0 -> vld=1 one cycle after 0xD, instr=0xABCD, cnt=1.
- Feed 3 words (0x1234, 0x5678, 0x9ABC) with acp=0, DEPTH=2 -> rdy drops after the second word completes; the 0x9 nibble presented while rdy=0 is ignored; cnt=2. Accept once -> rdy=1 next cycle, head=0x5678.
- Continuous stream with acp held high -> push and pop each 4 cycles; cnt never exceeds 1; words emerge in order with no loss over 16 words, pointers wrapping.
- Two nibbles 0xE,0xF, then flush together with a third nibble, then 0x1,0x2,0x3,0x4 -> only 0x1234 appears; the partial 0xEF word never appears.
- FIFO holding 2 words, flush and acp asserted together -> next cycle cnt=0, vld=0, rdy=1; no pop side effects.
- With IDLI_IBUF_BYPASS_EN, empty FIFO, acp=1 and nibbles 0xC,0xA,0xF,0xE -> vld=1 and instr=0xCAFE in the cycle of 0xE; cnt stays 0.
